chroma_blob_tracker: RTL and testbench
======================================

CHROMA_BLOB_TRACKER -- requirements
Module: chroma_blob_tracker

Interface
REQ-001 Parameter NUM_CLASSES, default 2: number of independent colour classes (1..8).
REQ-002 Parameter CNT_W, default 20: pixel-count width per class.
REQ-003 Parameter MIN_COUNT, default 64: minimum pixels per frame for a class to be reported as found.
REQ-004 PCLK  in  1  pixel clock; sole clock; all logic rising-edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 e_pix  in  1  input pixel valid this cycle.
REQ-007 sof  in  1  start-of-frame pulse; qualifies the first pixel of a frame; honoured even without e_pix.
REQ-008 Y  in  8  luma, unsigned.
REQ-009 Cb, Cr  in  8 each  chroma, signed two's complement, centred on 0.
REQ-010 x, y  in  10 each  pixel coordinates, unsigned.
REQ-011 cfg_we  in  1  threshold write strobe.
REQ-012 cfg_class  in  3  target class index; writes with index >= NUM_CLASSES are ignored.
REQ-013 cfg_field  in  3  0 Y_MIN, 1 Y_MAX, 2 CB_MIN, 3 CB_MAX, 4 CR_MIN, 5 CR_MAX; 6 and 7 ignored.
REQ-014 cfg_data  in  8  threshold value; signed for Cb/Cr fields, unsigned for Y fields.
REQ-015 pix_valid  out  1  registered copy of e_pix.
REQ-016 class_hit  out  NUM_CLASSES  per-class match mask for the pixel.
REQ-017 Y_out  out  8  luma with highlight applied.
REQ-018 res_valid  out  1  one-cycle pulse; frame results updated.
REQ-019 found  out  NUM_CLASSES  per-class found flag.
REQ-020 count  out  NUM_CLASSES*CNT_W  per-class pixel count, class k at bits [k*CNT_W +: CNT_W].
REQ-021 bbox  out  NUM_CLASSES*40  per-class {x_min, x_max, y_min, y_max}, 10 bits each, class k at bits [k*40 +: 40], x_min most significant.

Function
REQ-022 Classification: a pixel matches class k iff Y_MIN<=Y<=Y_MAX (unsigned) and CB_MIN<=Cb<=CB_MAX and CR_MIN<=Cr<=CR_MAX (signed); all bounds inclusive.
REQ-023 A window with min > max matches nothing.
REQ-024 Stage 1, one cycle after a cycle with e_pix=1: pix_valid=1, class_hit=match mask, Y_out={2'b11,Y[7:2]} if any hit else Y.
REQ-025 When e_pix=0: pix_valid=0 and class_hit=0 next cycle; Y_out holds its value.
REQ-026 Stage 2, one cycle after stage 1: each hit class increments its count and updates its bbox min/max with the pipelined x, y.
REQ-027 Counts saturate at 2^CNT_W-1; bbox updates continue after saturation.
REQ-028 sof travels through the same two-stage pipeline as the pixel.
REQ-029 Frame close, in the stage-2 cycle of sof: accumulated values are copied to count/bbox/found, res_valid pulses for 1 cycle, and accumulators restart.
REQ-030 On accumulator restart, a pixel carried with sof is counted in the new frame.
REQ-031 found[k] = (count_k >= MIN_COUNT) at frame close.
REQ-032 A class with zero count at frame close reports bbox=0.
REQ-033 Active frame accumulators restart with count=0, min=10'h3FF, max=0.
REQ-034 Consecutive sof pulses each close a frame; an empty frame reports count=0 and found=0.
REQ-035 cfg writes go to shadow registers.
REQ-036 Shadow thresholds become active in the same cycle sof is sampled, so the sof pixel uses the new thresholds.
REQ-037 A cfg write coincident with sof is captured in the shadow but applies at the following sof.
REQ-038 Multiple writes to one field before sof: the last write wins.

Reset
REQ-039 reset_n low: all outputs 0 except Y_out=0; accumulators and result registers are cleared.
REQ-040 Reset mid-frame discards partial accumulation; no res_valid follows.
REQ-041 Reset defaults, shadow and active, class 0: Y 0..255, Cb -110..-85, Cr -120..-40 (green).
REQ-042 Reset defaults, shadow and active, classes >= 1: min=max-inverted (Y 255..0, Cb/Cr 127..-128), disabled.
REQ-043 After reset release, the first sof closes an empty frame, giving res_valid with all counts 0.

Structure
REQ-044 Package tracker_pkg holds the cfg_field encodings, the default threshold constants and the bbox field offsets.
REQ-045 Sub-module chroma_window_cmp, instantiated once per class, performs the combinational 3-channel inclusive window compare.

Verification
REQ-046 Reset, then sof, then 100 pixels of Y=100, Cb=-100, Cr=-80 at x=10..109, y=5, then sof -> class_hit[0]=1 and Y_out=0xD9 at +1 cycle; res_valid with count0=100, found0=1, bbox0={10,109,5,5}.
REQ-047 Boundary pixels Cb=-110/-85 and Cb=-111/-84 -> first pair hits class 0; second pair does not.
REQ-048 Write class 1 Cb 20..40, Cr 20..40 mid-frame; send matching pixels before and after the next sof -> class 1 hits only after that sof.
REQ-049 A frame of 63 matching pixels -> found0=0, count0=63; a frame of 64 -> found0=1.
REQ-050 Saturation with CNT_W=4: 20 matching pixels -> count0=15.
REQ-051 Assert reset_n low mid-frame, then send sof -> single res_valid with counts 0, and thresholds back at default.

Source files
------------

// File: rtl/tracker_pkg.sv
// Shared types and constants for the chroma blob tracker: threshold record,
// cfg_field encodings, reset-default windows and bbox field layout.
package tracker_pkg;

    // One colour window; Y bounds unsigned, Cb/Cr bounds two's complement.
    typedef struct packed {
        logic [7:0] y_min;
        logic [7:0] y_max;
        logic [7:0] cb_min;
        logic [7:0] cb_max;
        logic [7:0] cr_min;
        logic [7:0] cr_max;
    } thr_t;

    localparam logic [2:0] FIELD_Y_MIN  = 3'd0;
    localparam logic [2:0] FIELD_Y_MAX  = 3'd1;
    localparam logic [2:0] FIELD_CB_MIN = 3'd2;
    localparam logic [2:0] FIELD_CB_MAX = 3'd3;
    localparam logic [2:0] FIELD_CR_MIN = 3'd4;
    localparam logic [2:0] FIELD_CR_MAX = 3'd5;

    // Class 0 defaults to green: Y 0..255, Cb -110..-85, Cr -120..-40.
    localparam thr_t THR_GREEN = '{
        y_min: 8'h00, y_max: 8'hFF,
        cb_min: 8'h92, cb_max: 8'hAB,
        cr_min: 8'h88, cr_max: 8'hD8
    };

    // Other classes default to inverted windows, which match nothing.
    localparam thr_t THR_DISABLED = '{
        y_min: 8'hFF, y_max: 8'h00,
        cb_min: 8'h7F, cb_max: 8'h80,
        cr_min: 8'h7F, cr_max: 8'h80
    };

    localparam int unsigned COORD_W       = 10;
    localparam int unsigned BBOX_W        = 40;
    localparam int unsigned BBOX_XMIN_OFF = 30;
    localparam int unsigned BBOX_XMAX_OFF = 20;
    localparam int unsigned BBOX_YMIN_OFF = 10;
    localparam int unsigned BBOX_YMAX_OFF = 0;

    function automatic thr_t default_thr(input int unsigned k);
        return (k == 0) ? THR_GREEN : THR_DISABLED;
    endfunction

    // Replace one field of a window; unknown field codes leave it untouched.
    function automatic thr_t write_field(input thr_t t, input logic [2:0] f,
                                         input logic [7:0] d);
        thr_t r;
        r = t;
        case (f)
            FIELD_Y_MIN:  r.y_min  = d;
            FIELD_Y_MAX:  r.y_max  = d;
            FIELD_CB_MIN: r.cb_min = d;
            FIELD_CB_MAX: r.cb_max = d;
            FIELD_CR_MIN: r.cr_min = d;
            FIELD_CR_MAX: r.cr_max = d;
            default:      r = t;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/chroma_window_cmp.sv
// Combinational inclusive window compare over Y (unsigned) and Cb/Cr (signed).
module chroma_window_cmp
    import tracker_pkg::*;
(
    input  logic [7:0] Y,
    input  logic [7:0] Cb,
    input  logic [7:0] Cr,
    input  thr_t       thr,
    output logic       hit
);

    logic y_ok;
    logic cb_ok;
    logic cr_ok;

    // An inverted window (min > max) fails one of the two bounds for every value.
    always_comb begin
        y_ok  = (Y >= thr.y_min) && (Y <= thr.y_max);
        cb_ok = ($signed(Cb) >= $signed(thr.cb_min)) && ($signed(Cb) <= $signed(thr.cb_max));
        cr_ok = ($signed(Cr) >= $signed(thr.cr_min)) && ($signed(Cr) <= $signed(thr.cr_max));
        hit   = y_ok && cb_ok && cr_ok;
    end

endmodule

// File: rtl/chroma_blob_tracker.sv
// Per-pixel colour classification with highlight, plus per-frame pixel count
// and bounding box per class, published at each start of frame.
module chroma_blob_tracker
    import tracker_pkg::*;
#(
    parameter int unsigned NUM_CLASSES = 2,
    parameter int unsigned CNT_W       = 20,
    parameter int unsigned MIN_COUNT   = 64
) (
    input  logic                         PCLK,
    input  logic                         reset_n,
    input  logic                         e_pix,
    input  logic                         sof,
    input  logic [7:0]                   Y,
    input  logic [7:0]                   Cb,
    input  logic [7:0]                   Cr,
    input  logic [9:0]                   x,
    input  logic [9:0]                   y,
    input  logic                         cfg_we,
    input  logic [2:0]                   cfg_class,
    input  logic [2:0]                   cfg_field,
    input  logic [7:0]                   cfg_data,
    output logic                         pix_valid,
    output logic [NUM_CLASSES-1:0]       class_hit,
    output logic [7:0]                   Y_out,
    output logic                         res_valid,
    output logic [NUM_CLASSES-1:0]       found,
    output logic [NUM_CLASSES*CNT_W-1:0] count,
    output logic [NUM_CLASSES*40-1:0]    bbox
);

    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]   CNT_ONE   = 1;
    localparam logic [COORD_W-1:0] COORD_MAX = '1;

    thr_t shadow_q [NUM_CLASSES];
    thr_t active_q [NUM_CLASSES];
    thr_t thr_sel  [NUM_CLASSES];
    logic [NUM_CLASSES-1:0] match;

    logic         s1_sof_q;
    logic [9:0]   s1_x_q;
    logic [9:0]   s1_y_q;

    logic [CNT_W-1:0]   acc_cnt_q  [NUM_CLASSES];
    logic [CNT_W-1:0]   acc_cnt_d  [NUM_CLASSES];
    logic [COORD_W-1:0] acc_xmin_q [NUM_CLASSES];
    logic [COORD_W-1:0] acc_xmin_d [NUM_CLASSES];
    logic [COORD_W-1:0] acc_xmax_q [NUM_CLASSES];
    logic [COORD_W-1:0] acc_xmax_d [NUM_CLASSES];
    logic [COORD_W-1:0] acc_ymin_q [NUM_CLASSES];
    logic [COORD_W-1:0] acc_ymin_d [NUM_CLASSES];
    logic [COORD_W-1:0] acc_ymax_q [NUM_CLASSES];
    logic [COORD_W-1:0] acc_ymax_d [NUM_CLASSES];

    // The sof pixel is classified against the shadow set it is about to activate.
    for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_cls
        assign thr_sel[k] = sof ? shadow_q[k] : active_q[k];

        chroma_window_cmp u_cmp (
            .Y   (Y),
            .Cb  (Cb),
            .Cr  (Cr),
            .thr (thr_sel[k]),
            .hit (match[k])
        );
    end

    // Shadow capture from cfg writes; shadow-to-active transfer on sof.
    always_ff @(posedge PCLK or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
                shadow_q[k] <= default_thr(k);
                active_q[k] <= default_thr(k);
            end
        end else begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
                // Old shadow value is transferred; a coincident write waits a frame.
                if (sof) begin
                    active_q[k] <= shadow_q[k];
                end
                if (cfg_we && (cfg_class == 3'(k))) begin
                    shadow_q[k] <= write_field(shadow_q[k], cfg_field, cfg_data);
                end
            end
        end
    end

    // Stage 1: register pixel classification, highlight and carried sof/coords.
    always_ff @(posedge PCLK or negedge reset_n) begin
        if (!reset_n) begin
            pix_valid <= 1'b0;
            class_hit <= '0;
            Y_out     <= 8'h00;
            s1_sof_q  <= 1'b0;
            s1_x_q    <= '0;
            s1_y_q    <= '0;
        end else begin
            pix_valid <= e_pix;
            class_hit <= e_pix ? match : '0;
            if (e_pix) begin
                Y_out <= (|match) ? {2'b11, Y[7:2]} : Y;
            end
            s1_sof_q <= sof;
            s1_x_q   <= x;
            s1_y_q   <= y;
        end
    end

    // Stage 2 next state: restart on sof, then fold in the stage-1 hits.
    always_comb begin
        for (int k = 0; k < NUM_CLASSES; k++) begin
            if (s1_sof_q) begin
                acc_cnt_d[k]  = '0;
                acc_xmin_d[k] = COORD_MAX;
                acc_xmax_d[k] = '0;
                acc_ymin_d[k] = COORD_MAX;
                acc_ymax_d[k] = '0;
            end else begin
                acc_cnt_d[k]  = acc_cnt_q[k];
                acc_xmin_d[k] = acc_xmin_q[k];
                acc_xmax_d[k] = acc_xmax_q[k];
                acc_ymin_d[k] = acc_ymin_q[k];
                acc_ymax_d[k] = acc_ymax_q[k];
            end
            if (class_hit[k]) begin
                if (acc_cnt_d[k] != CNT_MAX) begin
                    acc_cnt_d[k] = acc_cnt_d[k] + CNT_ONE;
                end
                if (s1_x_q < acc_xmin_d[k]) acc_xmin_d[k] = s1_x_q;
                if (s1_x_q > acc_xmax_d[k]) acc_xmax_d[k] = s1_x_q;
                if (s1_y_q < acc_ymin_d[k]) acc_ymin_d[k] = s1_y_q;
                if (s1_y_q > acc_ymax_d[k]) acc_ymax_d[k] = s1_y_q;
            end
        end
    end

    // Stage 2 accumulator registers.
    always_ff @(posedge PCLK or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
                acc_cnt_q[k]  <= '0;
                acc_xmin_q[k] <= COORD_MAX;
                acc_xmax_q[k] <= '0;
                acc_ymin_q[k] <= COORD_MAX;
                acc_ymax_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
                acc_cnt_q[k]  <= acc_cnt_d[k];
                acc_xmin_q[k] <= acc_xmin_d[k];
                acc_xmax_q[k] <= acc_xmax_d[k];
                acc_ymin_q[k] <= acc_ymin_d[k];
                acc_ymax_q[k] <= acc_ymax_d[k];
            end
        end
    end

    // Frame close: publish the closing frame's totals when sof reaches stage 2.
    always_ff @(posedge PCLK or negedge reset_n) begin
        if (!reset_n) begin
            res_valid <= 1'b0;
            found     <= '0;
            count     <= '0;
            bbox      <= '0;
        end else begin
            res_valid <= s1_sof_q;
            if (s1_sof_q) begin
                for (int k = 0; k < NUM_CLASSES; k++) begin
                    count[k*CNT_W +: CNT_W] <= acc_cnt_q[k];
                    found[k] <= (32'(acc_cnt_q[k]) >= MIN_COUNT);
                    if (acc_cnt_q[k] == '0) begin
                        bbox[k*BBOX_W +: BBOX_W] <= '0;
                    end else begin
                        bbox[k*BBOX_W + BBOX_XMIN_OFF +: COORD_W] <= acc_xmin_q[k];
                        bbox[k*BBOX_W + BBOX_XMAX_OFF +: COORD_W] <= acc_xmax_q[k];
                        bbox[k*BBOX_W + BBOX_YMIN_OFF +: COORD_W] <= acc_ymin_q[k];
                        bbox[k*BBOX_W + BBOX_YMAX_OFF +: COORD_W] <= acc_ymax_q[k];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_chroma_blob_tracker.sv
// Scoreboard bench: stimulus pushes expected pixel/frame responses, a monitor
// pops and compares them when the DUTs present output. A second instance with
// CNT_W=4 shares the stimulus to exercise count saturation.
module tb_chroma_blob_tracker;

    logic       PCLK = 1'b0;
    logic       reset_n = 1'b0;
    logic       e_pix = 1'b0;
    logic       sof = 1'b0;
    logic [7:0] Y = 8'h00;
    logic [7:0] Cb = 8'h00;
    logic [7:0] Cr = 8'h00;
    logic [9:0] x = 10'd0;
    logic [9:0] y = 10'd0;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_class = 3'd0;
    logic [2:0] cfg_field = 3'd0;
    logic [7:0] cfg_data = 8'h00;

    logic        pix_valid, res_valid;
    logic [1:0]  class_hit, found;
    logic [7:0]  Y_out;
    logic [39:0] count;
    logic [79:0] bbox;

    logic        pix_valid_s, res_valid_s;
    logic [1:0]  class_hit_s, found_s;
    logic [7:0]  Y_out_s;
    logic [7:0]  count_s;
    logic [79:0] bbox_s;

    chroma_blob_tracker #(.NUM_CLASSES(2), .CNT_W(20), .MIN_COUNT(64)) u_dut (
        .PCLK(PCLK), .reset_n(reset_n), .e_pix(e_pix), .sof(sof), .Y(Y), .Cb(Cb), .Cr(Cr),
        .x(x), .y(y), .cfg_we(cfg_we), .cfg_class(cfg_class), .cfg_field(cfg_field),
        .cfg_data(cfg_data), .pix_valid(pix_valid), .class_hit(class_hit), .Y_out(Y_out),
        .res_valid(res_valid), .found(found), .count(count), .bbox(bbox)
    );

    chroma_blob_tracker #(.NUM_CLASSES(2), .CNT_W(4), .MIN_COUNT(64)) u_dut_sat (
        .PCLK(PCLK), .reset_n(reset_n), .e_pix(e_pix), .sof(sof), .Y(Y), .Cb(Cb), .Cr(Cr),
        .x(x), .y(y), .cfg_we(cfg_we), .cfg_class(cfg_class), .cfg_field(cfg_field),
        .cfg_data(cfg_data), .pix_valid(pix_valid_s), .class_hit(class_hit_s),
        .Y_out(Y_out_s), .res_valid(res_valid_s), .found(found_s), .count(count_s),
        .bbox(bbox_s)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        int         cyc;
        logic [1:0] hit;
        logic [7:0] yo;
    } pix_exp_t;

    typedef struct {
        int          cyc;
        int          c0;
        int          c1;
        logic [39:0] b0;
        logic [39:0] b1;
    } res_exp_t;

    pix_exp_t pix_q[$];
    res_exp_t res_q[$];
    res_exp_t sat_q[$];
    pix_exp_t pe;
    res_exp_t re;
    res_exp_t rs;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int drv_cyc = 0;

    logic       pend_we = 1'b0;
    logic [2:0] pend_class = 3'd0;
    logic [2:0] pend_field = 3'd0;
    logic [7:0] pend_data = 8'h00;

    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [39:0] bb(input int a, input int b, input int c, input int d);
        return {10'(a), 10'(b), 10'(c), 10'(d)};
    endfunction

    function automatic int sat15(input int c);
        return (c > 15) ? 15 : c;
    endfunction

    // Monitor: compare whatever the DUTs present against the queued expectations.
    always @(negedge PCLK) begin
        if (pix_valid === 1'b1) begin
            if (pix_q.size() == 0) begin
                chk("pix_unexpected", 128'd1, 128'd0);
            end else begin
                pe = pix_q.pop_front();
                chk("pix_cycle", 128'(cyc), 128'(pe.cyc));
                chk("class_hit", 128'(class_hit), 128'(pe.hit));
                chk("Y_out", 128'(Y_out), 128'(pe.yo));
            end
        end else if (reset_n === 1'b1) begin
            chk("class_hit_idle", 128'(class_hit), 128'd0);
        end
        if (res_valid === 1'b1) begin
            if (res_q.size() == 0) begin
                chk("res_unexpected", 128'd1, 128'd0);
            end else begin
                re = res_q.pop_front();
                chk("res_cycle", 128'(cyc), 128'(re.cyc));
                chk("count", 128'(count), 128'({20'(re.c1), 20'(re.c0)}));
                chk("found", 128'(found), 128'({re.c1 >= 64, re.c0 >= 64}));
                chk("bbox", 128'(bbox), 128'({re.b1, re.b0}));
            end
        end
        if (res_valid_s === 1'b1) begin
            if (sat_q.size() == 0) begin
                chk("sat_res_unexpected", 128'd1, 128'd0);
            end else begin
                rs = sat_q.pop_front();
                chk("sat_count", 128'(count_s), 128'({4'(sat15(rs.c1)), 4'(sat15(rs.c0))}));
                chk("sat_found", 128'(found_s), 128'd0);
                chk("sat_bbox", 128'(bbox_s), 128'({rs.b1, rs.b0}));
            end
        end
    end

    task automatic drive(input bit s, input bit ep, input logic [7:0] yy, input logic [7:0] cb,
                         input logic [7:0] cr, input int px, input int py);
        @(negedge PCLK);
        sof = s; e_pix = ep; Y = yy; Cb = cb; Cr = cr; x = 10'(px); y = 10'(py);
        cfg_we = pend_we; cfg_class = pend_class; cfg_field = pend_field; cfg_data = pend_data;
        pend_we = 1'b0;
        drv_cyc = cyc;
    endtask

    task automatic pix(input bit s, input logic [7:0] yy, input logic [7:0] cb,
                       input logic [7:0] cr, input int px, input int py, input logic [1:0] hit);
        pix_exp_t e;
        drive(s, 1'b1, yy, cb, cr, px, py);
        e.cyc = drv_cyc + 1;
        e.hit = hit;
        e.yo  = (hit != 2'b00) ? {2'b11, yy[7:2]} : yy;
        pix_q.push_back(e);
    endtask

    task automatic sof_only();
        drive(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 0, 0);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 0, 0);
    endtask

    task automatic cfg(input logic [2:0] cls, input logic [2:0] fld, input logic [7:0] d);
        pend_we = 1'b1; pend_class = cls; pend_field = fld; pend_data = d;
        drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 0, 0);
    endtask

    // Expected frame result for the sof most recently driven.
    task automatic exp_res(input int c0, input logic [39:0] b0, input int c1,
                           input logic [39:0] b1);
        res_exp_t r;
        r.cyc = drv_cyc + 2; r.c0 = c0; r.c1 = c1; r.b0 = b0; r.b1 = b1;
        res_q.push_back(r);
        sat_q.push_back(r);
    endtask

    initial begin
        repeat (3) @(negedge PCLK);
        chk("rst_pix_valid", 128'(pix_valid), 128'd0);
        chk("rst_class_hit", 128'(class_hit), 128'd0);
        chk("rst_Y_out", 128'(Y_out), 128'd0);
        chk("rst_res_valid", 128'(res_valid), 128'd0);
        chk("rst_found", 128'(found), 128'd0);
        chk("rst_count", 128'(count), 128'd0);
        chk("rst_bbox", 128'(bbox), 128'd0);
        @(negedge PCLK);
        reset_n = 1'b1;

        // First sof after reset closes an empty frame.
        sof_only();
        exp_res(0, 40'd0, 0, 40'd0);

        // 100 green pixels on one row.
        for (int i = 0; i < 100; i++) pix(1'b0, 8'd100, 8'(-100), 8'(-80), 10 + i, 5, 2'b01);
        sof_only();
        exp_res(100, bb(10, 109, 5, 5), 0, 40'd0);

        // Cb boundaries: inclusive edges hit, one step outside misses.
        pix(1'b0, 8'd50, 8'(-110), 8'(-60), 1, 1, 2'b01);
        pix(1'b0, 8'd50, 8'(-85),  8'(-60), 2, 2, 2'b01);
        pix(1'b0, 8'd50, 8'(-111), 8'(-60), 3, 3, 2'b00);
        pix(1'b0, 8'd50, 8'(-84),  8'(-60), 4, 4, 2'b00);
        sof_only();
        exp_res(2, bb(1, 2, 1, 2), 0, 40'd0);

        // Class 1 programmed mid-frame; ignored writes must not disturb class 0.
        cfg(3'd1, 3'd0, 8'd0);
        cfg(3'd1, 3'd1, 8'd255);
        cfg(3'd1, 3'd2, 8'd30);
        cfg(3'd1, 3'd2, 8'd20);
        cfg(3'd1, 3'd3, 8'd40);
        cfg(3'd1, 3'd4, 8'd20);
        cfg(3'd1, 3'd5, 8'd40);
        cfg(3'd2, 3'd2, 8'd0);
        cfg(3'd0, 3'd6, 8'd0);
        pix(1'b0, 8'd80, 8'd30, 8'd30, 200, 100, 2'b00);
        // sof pixel uses the new window; coincident write waits for the next sof.
        pend_we = 1'b1; pend_class = 3'd1; pend_field = 3'd5; pend_data = 8'd25;
        pix(1'b1, 8'd80, 8'd30, 8'd30, 300, 150, 2'b10);
        exp_res(0, 40'd0, 0, 40'd0);
        pix(1'b0, 8'd80, 8'd30, 8'd30, 301, 151, 2'b10);
        pix(1'b1, 8'd80, 8'd30, 8'd30, 5, 6, 2'b00);
        exp_res(0, 40'd0, 2, bb(300, 301, 150, 151));

        // MIN_COUNT threshold: 63 then 64 pixels.
        for (int i = 0; i < 63; i++) pix(1'b0, 8'd100, 8'(-100), 8'(-80), 20 + i, 30, 2'b01);
        sof_only();
        exp_res(63, bb(20, 82, 30, 30), 0, 40'd0);
        for (int i = 0; i < 64; i++) pix(1'b0, 8'd100, 8'(-100), 8'(-80), i, 7, 2'b01);
        sof_only();
        exp_res(64, bb(0, 63, 7, 7), 0, 40'd0);

        // Back-to-back sof: empty frame.
        sof_only();
        exp_res(0, 40'd0, 0, 40'd0);

        // Reset mid-frame discards the partial frame and restores default windows.
        pix(1'b0, 8'd100, 8'(-100), 8'(-80), 7, 8, 2'b01);
        pix(1'b0, 8'd100, 8'(-100), 8'(-80), 8, 8, 2'b01);
        pix(1'b0, 8'd100, 8'(-100), 8'(-80), 9, 8, 2'b01);
        idle(3);
        @(negedge PCLK);
        reset_n = 1'b0;
        @(negedge PCLK);
        chk("mid_rst_Y_out", 128'(Y_out), 128'd0);
        chk("mid_rst_count", 128'(count), 128'd0);
        @(negedge PCLK);
        reset_n = 1'b1;
        idle(4);
        sof_only();
        exp_res(0, 40'd0, 0, 40'd0);
        pix(1'b0, 8'd80, 8'd30, 8'd30, 9, 9, 2'b00);
        pix(1'b0, 8'd100, 8'(-100), 8'(-80), 4, 4, 2'b01);
        sof_only();
        exp_res(1, bb(4, 4, 4, 4), 0, 40'd0);

        idle(4);
        for (int i = 0; i < 20; i++) begin
            if (pix_q.size() + res_q.size() + sat_q.size() == 0) break;
            @(negedge PCLK);
        end
        chk("queue_drain", 128'(pix_q.size() + res_q.size() + sat_q.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
